lpm_search: RTL and testbench
=============================

Name: lpm_search

Overview:
- Longest-prefix-match search engine for the router output-port-lookup pcore.
- Takes the destination IPv4 address of the current packet and scans the 32-entry LPM table (prefix, mask, valid).
- Returns hit flag plus winning entry index, which the downstream result-latch stage uses to select next-hop and output-queue words.
- Multi-cycle scan, request/response handshake on both sides.

Parameters:
- NUM_ENTRIES, 32, LPM table depth; power of two.
- ENTRIES_PER_CYCLE, 4, entries compared per search cycle; must divide NUM_ENTRIES.
- INDEX_WIDTH, 5, width of index output; log2(NUM_ENTRIES).

Ports:
- AXI_ACLK  in  1  clock.
- AXI_RESET  in  1  reset, asynchronous, active-high.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  engine can accept request.
- req_ip  in  32  destination IP to look up.
- lpm_table_ip  in  32*NUM_ENTRIES  entry i prefix at bits [32i+31:32i].
- lpm_table_mask  in  32*NUM_ENTRIES  entry i mask, same packing.
- lpm_table_valid  in  NUM_ENTRIES  entry i valid.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- lpm_hit  out  1  a valid entry matched.
- index_hit  out  INDEX_WIDTH  winning entry index; 0 on miss.

Behaviour:
- Clock and reset: one clock AXI_ACLK; reset AXI_RESET is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - req_ready = 1 (combinational from state).
  - rsp_valid, lpm_hit, index_hit, internal best_mask/best_idx/best_found, group counter = 0.
- Reset mid-operation: any in-flight search is dropped without a response.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid at an edge: latch req_ip, clear best_found/best_mask/best_idx, set group = 0, go to SEARCH.
- SEARCH:
  - req_ready = 0.
  - Each edge evaluates entries group*ENTRIES_PER_CYCLE .. +ENTRIES_PER_CYCLE-1.
  - Entry i matches when lpm_table_valid[i] && ((ip_latched & mask_i) == (prefix_i & mask_i)).
  - Candidate replaces best when it matches && (!best_found || mask_i > best_mask), with an unsigned 32-bit compare.
  - Equal masks: the lower index wins. Strictly-greater compare across groups; lowest index among equals inside a group.
  - After the last group (group == NUM_ENTRIES/ENTRIES_PER_CYCLE-1): register lpm_hit = best_found and index_hit = best_found ? best_idx : 0, assert rsp_valid, go to DONE.
- Latency: rsp_valid rises exactly NUM_ENTRIES/ENTRIES_PER_CYCLE edges after the accepting edge (8 with defaults).
- DONE:
  - rsp_valid = 1; lpm_hit and index_hit held stable.
  - On rsp_ready at an edge: rsp_valid <= 0, go to IDLE. lpm_hit and index_hit keep their value until the next result.
  - req_ready = 0 in DONE, so a new request is never accepted in the same edge as a response handshake. Minimum request spacing is NUM_ENTRIES/ENTRIES_PER_CYCLE+2 cycles.
- Boundary cases:
  - Mask 0 with valid = 1 is a default route: matches every address and loses to any longer mask.
  - All entries invalid: lpm_hit = 0, index_hit = 0.
  - Non-contiguous masks are ranked by numeric value, with no error.
  - rsp_ready held high in advance: response completes in its first DONE cycle.
  - Table inputs are read live each SEARCH cycle. Software updates during traffic are unsupported and their result is not checked.
- Group counter wraps only through the SEARCH->DONE transition; no other wrap-around.

Optional Feature:
- Macro: LPM_SEARCH_MISS_COUNT_EN.
- Defined:
  - Adds output lpm_miss_count [31:0], reset to 0.
  - Increments by 1 on each SEARCH->DONE transition with best_found = 0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by AXI_RESET only.
- Undefined: port absent, no counter logic; all other behaviour identical.

Test Plan:
- Reset: assert AXI_RESET mid-SEARCH -> immediately req_ready=1, rsp_valid=0, lpm_hit=0, index_hit=0; no response emitted.
- Single match:
  - Setup: entry 3 = 10.0.0.0/255.0.0.0 valid, others invalid.
  - Request 10.1.2.3 -> rsp_valid 8 edges after accept, lpm_hit=1, index_hit=3.
- Longest prefix:
  - Setup: entry 2 = 10.0.0.0/8, entry 20 = 10.1.0.0/16, entry 31 = 0.0.0.0/0, all valid.
  - Request 10.1.9.9 -> index_hit=20. Request 10.2.0.1 -> index_hit=2. Request 192.168.0.1 -> index_hit=31.
- Tie and valid:
  - Setup: entries 5 and 6 both 10.1.0.0/16 valid -> index_hit=5. Clear valid[5] -> index_hit=6.
  - Clear all valid -> lpm_hit=0, index_hit=0; with LPM_SEARCH_MISS_COUNT_EN, lpm_miss_count increments by 1.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable, req_ready=0 throughout.
  - Raise rsp_ready -> rsp_valid drops next edge, req_ready=1.
- Back-to-back: req_valid held high with 4 queued addresses and rsp_ready=1 -> 4 responses, in order, spaced 10 cycles apart.

Source files
------------

// File: rtl/lpm_search.sv
`default_nettype none
// ============================================================================
// Module   : lpm_search
// Brief    : Longest-prefix-match search engine. Scans an LPM table of
//            (prefix, mask, valid) entries, ENTRIES_PER_CYCLE per cycle, and
//            returns hit flag and winning entry index over a valid/ready
//            handshake. The optional miss counter is enabled by defining
//            LPM_SEARCH_MISS_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lpm_search #(
  parameter int NUM_ENTRIES       = 32,
  parameter int ENTRIES_PER_CYCLE = 4,
  parameter int INDEX_WIDTH       = 5
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_RESET,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_ip,
  input  logic [32*NUM_ENTRIES-1:0]     lpm_table_ip,
  input  logic [32*NUM_ENTRIES-1:0]     lpm_table_mask,
  input  logic [NUM_ENTRIES-1:0]        lpm_table_valid,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          lpm_hit,
`ifdef LPM_SEARCH_MISS_COUNT_EN
  output logic [31:0]                   lpm_miss_count,
`endif
  output logic [INDEX_WIDTH-1:0]        index_hit
);

  localparam int NUM_GROUPS = NUM_ENTRIES / ENTRIES_PER_CYCLE;
  localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [GW-1:0] LAST_GROUP = GW'(NUM_GROUPS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [31:0]            ip_q;
  logic [GW-1:0]          group_q;
  logic                   best_found_q;
  logic [31:0]            best_mask_q;
  logic [INDEX_WIDTH-1:0] best_idx_q;
  logic                   lpm_hit_q;
  logic [INDEX_WIDTH-1:0] index_hit_q;

  // Running best after folding in the current group's lanes
  logic                   found_d;
  logic [31:0]            mask_d;
  logic [INDEX_WIDTH-1:0] idx_d;

  logic                   lane_match [ENTRIES_PER_CYCLE];
  logic [31:0]            lane_mask  [ENTRIES_PER_CYCLE];
  logic [INDEX_WIDTH-1:0] lane_idx   [ENTRIES_PER_CYCLE];

  wire last_group = (group_q == LAST_GROUP);

  // Per-lane compare of the latched address against one table entry
  genvar k;
  generate
    for (k = 0; k < ENTRIES_PER_CYCLE; k++) begin : g_lane
      logic [31:0] lane_prefix;
      assign lane_idx[k]    = INDEX_WIDTH'(group_q) * INDEX_WIDTH'(ENTRIES_PER_CYCLE)
                              + INDEX_WIDTH'(k);
      assign lane_prefix    = lpm_table_ip[32*lane_idx[k] +: 32];
      assign lane_mask[k]   = lpm_table_mask[32*lane_idx[k] +: 32];
      assign lane_match[k]  = lpm_table_valid[lane_idx[k]] &&
                              ((ip_q & lane_mask[k]) == (lane_prefix & lane_mask[k]));
    end
  endgenerate

  // Fold lanes in ascending index with a strict compare so the lowest index wins ties
  always_comb begin
    found_d = best_found_q;
    mask_d  = best_mask_q;
    idx_d   = best_idx_q;
    for (int i = 0; i < ENTRIES_PER_CYCLE; i++) begin
      if (lane_match[i] && (!found_d || (lane_mask[i] > mask_d))) begin
        found_d = 1'b1;
        mask_d  = lane_mask[i];
        idx_d   = lane_idx[i];
      end
    end
  end

  // State register
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid)  state_d = S_SEARCH;
      S_SEARCH: if (last_group) state_d = S_DONE;
      S_DONE:   if (rsp_ready)  state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and result registers
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_DONE);
    lpm_hit   = lpm_hit_q;
    index_hit = index_hit_q;
  end

  // Search datapath: latch request, accumulate best match, publish result
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      ip_q         <= '0;
      group_q      <= '0;
      best_found_q <= 1'b0;
      best_mask_q  <= '0;
      best_idx_q   <= '0;
      lpm_hit_q    <= 1'b0;
      index_hit_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            ip_q         <= req_ip;
            group_q      <= '0;
            best_found_q <= 1'b0;
            best_mask_q  <= '0;
            best_idx_q   <= '0;
          end
        end
        S_SEARCH: begin
          best_found_q <= found_d;
          best_mask_q  <= mask_d;
          best_idx_q   <= idx_d;
          if (last_group) begin
            group_q     <= '0;
            lpm_hit_q   <= found_d;
            index_hit_q <= found_d ? idx_d : '0;
          end else begin
            group_q     <= group_q + GW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LPM_SEARCH_MISS_COUNT_EN
  logic [31:0] miss_count_q;

  // Saturating count of completed searches that found no match
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      miss_count_q <= '0;
    end else if ((state_q == S_SEARCH) && last_group && !found_d && !(&miss_count_q)) begin
      miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign lpm_miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lpm_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_lpm_search
// Brief    : Directed self-checking bench for lpm_search.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lpm_search;

  logic                 AXI_ACLK;
  logic                 AXI_RESET;
  logic                 req_valid;
  logic                 req_ready;
  logic [31:0]          req_ip;
  logic [32*32-1:0]     lpm_table_ip;
  logic [32*32-1:0]     lpm_table_mask;
  logic [31:0]          lpm_table_valid;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 lpm_hit;
  logic [4:0]           index_hit;
`ifdef LPM_SEARCH_MISS_COUNT_EN
  logic [31:0]          lpm_miss_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  lpm_search #(
    .NUM_ENTRIES      (32),
    .ENTRIES_PER_CYCLE(4),
    .INDEX_WIDTH      (5)
  ) dut (
    .AXI_ACLK       (AXI_ACLK),
    .AXI_RESET      (AXI_RESET),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_ip         (req_ip),
    .lpm_table_ip   (lpm_table_ip),
    .lpm_table_mask (lpm_table_mask),
    .lpm_table_valid(lpm_table_valid),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .lpm_hit        (lpm_hit),
`ifdef LPM_SEARCH_MISS_COUNT_EN
    .lpm_miss_count (lpm_miss_count),
`endif
    .index_hit      (index_hit)
  );

  initial AXI_ACLK = 1'b0;
  always #5 AXI_ACLK = ~AXI_ACLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int i, input logic [31:0] p, input logic [31:0] m, input logic v);
    lpm_table_ip[32*i +: 32]   = p;
    lpm_table_mask[32*i +: 32] = m;
    lpm_table_valid[i]         = v;
  endtask

  task automatic clear_table();
    lpm_table_ip    = '0;
    lpm_table_mask  = '0;
    lpm_table_valid = '0;
  endtask

  // Issue one request, check latency and result, then complete the handshake
  task automatic lookup(input logic [31:0] ip, input string tag,
                        input logic exp_hit, input logic [4:0] exp_idx);
    int lat;
    check_eq({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_ip    = ip;
    req_valid = 1'b1;
    @(posedge AXI_ACLK); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge AXI_ACLK); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 32'd8);
    check_eq({tag, "_hit"}, {31'd0, lpm_hit}, {31'd0, exp_hit});
    check_eq({tag, "_idx"}, {27'd0, index_hit}, {27'd0, exp_idx});
    rsp_ready = 1'b1;
    @(posedge AXI_ACLK); #1;
    rsp_ready = 1'b0;
    check_eq({tag, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  logic [31:0] b2b_ip  [4];
  logic [4:0]  b2b_idx [4];

  initial begin
    int lat;
    int seen;
    int nreq;
    int nrsp;
    int last_t;
    int t;
    logic acc;
    logic fire;
    int exp_miss;

    AXI_RESET = 1'b1;
    req_valid = 1'b0;
    req_ip    = '0;
    rsp_ready = 1'b0;
    exp_miss  = 0;
    clear_table();

    // Reset state
    #12;
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_lpm_hit",   {31'd0, lpm_hit},   32'd0);
    check_eq("rst_index_hit", {27'd0, index_hit}, 32'd0);
    @(negedge AXI_ACLK);
    AXI_RESET = 1'b0;
    @(posedge AXI_ACLK); #1;

    // Single match: entry 3 = 10.0.0.0/8
    set_entry(3, 32'h0A000000, 32'hFF000000, 1'b1);
    lookup(32'h0A010203, "single", 1'b1, 5'd3);

    // Longest prefix with default route
    clear_table();
    set_entry(2,  32'h0A000000, 32'hFF000000, 1'b1);
    set_entry(20, 32'h0A010000, 32'hFFFF0000, 1'b1);
    set_entry(31, 32'h00000000, 32'h00000000, 1'b1);
    lookup(32'h0A010909, "lp16",    1'b1, 5'd20);
    lookup(32'h0A020001, "lp8",     1'b1, 5'd2);
    lookup(32'hC0A80001, "lpdflt",  1'b1, 5'd31);

    // Tie within a group, then valid cleared on the winner
    clear_table();
    set_entry(5, 32'h0A010000, 32'hFFFF0000, 1'b1);
    set_entry(6, 32'h0A010000, 32'hFFFF0000, 1'b1);
    lookup(32'h0A017777, "tie56",   1'b1, 5'd5);
    lpm_table_valid[5] = 1'b0;
    lookup(32'h0A017777, "tie6",    1'b1, 5'd6);

    // Tie across groups: lower index (group 0) must survive
    clear_table();
    set_entry(30, 32'h0A010000, 32'hFFFF0000, 1'b1);
    set_entry(1,  32'h0A010000, 32'hFFFF0000, 1'b1);
    lookup(32'h0A010001, "tiexg",   1'b1, 5'd1);

    // Non-contiguous masks ranked numerically: 0xF0000000 beats 0x0000000F
    clear_table();
    set_entry(4, 32'h10000000, 32'hF0000000, 1'b1);
    set_entry(7, 32'h00000005, 32'h0000000F, 1'b1);
    lookup(32'h10000005, "noncontig", 1'b1, 5'd4);

    // All entries invalid (contents left in place)
    lpm_table_valid = '0;
    lookup(32'h10000005, "allinv", 1'b0, 5'd0);
    exp_miss++;
`ifdef LPM_SEARCH_MISS_COUNT_EN
    check_eq("miss_count", lpm_miss_count, exp_miss);
`endif

    // Backpressure: hold rsp_ready low for 5 cycles
    clear_table();
    set_entry(9, 32'hC0A80000, 32'hFFFF0000, 1'b1);
    req_ip = 32'hC0A80101; req_valid = 1'b1;
    @(posedge AXI_ACLK); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge AXI_ACLK); #1;
      lat++;
    end
    check_eq("bp_latency", lat, 32'd8);
    for (int c = 0; c < 5; c++) begin
      @(posedge AXI_ACLK); #1;
      check_eq("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check_eq("bp_hit",       {31'd0, lpm_hit},   32'd1);
      check_eq("bp_idx",       {27'd0, index_hit}, 32'd9);
    end
    rsp_ready = 1'b1;
    @(posedge AXI_ACLK); #1;
    rsp_ready = 1'b0;
    check_eq("bp_rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("bp_rel_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("bp_hold_idx",      {27'd0, index_hit}, 32'd9);

    // Back-to-back: req_valid held high, rsp_ready held high
    clear_table();
    set_entry(2,  32'h0A000000, 32'hFF000000, 1'b1);
    set_entry(20, 32'h0A010000, 32'hFFFF0000, 1'b1);
    set_entry(31, 32'h00000000, 32'h00000000, 1'b1);
    b2b_ip[0] = 32'h0A010909; b2b_idx[0] = 5'd20;
    b2b_ip[1] = 32'hC0A80001; b2b_idx[1] = 5'd31;
    b2b_ip[2] = 32'h0A090909; b2b_idx[2] = 5'd2;
    b2b_ip[3] = 32'h0A01C801; b2b_idx[3] = 5'd20;
    nreq = 0; nrsp = 0; last_t = -1; t = 0;
    req_ip = b2b_ip[0]; req_valid = 1'b1; rsp_ready = 1'b1;
    while (nrsp < 4 && t < 80) begin
      acc  = req_ready && req_valid;
      fire = rsp_valid && rsp_ready;
      if (fire) begin
        check_eq("b2b_hit", {31'd0, lpm_hit}, 32'd1);
        check_eq("b2b_idx", {27'd0, index_hit}, {27'd0, b2b_idx[nrsp]});
        if (last_t >= 0) check_eq("b2b_spacing", t - last_t, 32'd10);
        last_t = t;
        nrsp++;
      end
      @(posedge AXI_ACLK); #1;
      t++;
      if (acc) begin
        nreq++;
        if (nreq < 4) req_ip = b2b_ip[nreq];
        else          req_valid = 1'b0;
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    check_eq("b2b_count", nrsp, 32'd4);

    // Reset mid-search: everything clears at once, no response follows
    @(posedge AXI_ACLK); #1;
    set_entry(2, 32'h0A000000, 32'hFF000000, 1'b1);
    req_ip = 32'h0A020001; req_valid = 1'b1;
    @(posedge AXI_ACLK); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge AXI_ACLK); #1;
    end
    #2;
    AXI_RESET = 1'b1;
    #1;
    exp_miss = 0;
    check_eq("mrst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("mrst_lpm_hit",   {31'd0, lpm_hit},   32'd0);
    check_eq("mrst_index_hit", {27'd0, index_hit}, 32'd0);
`ifdef LPM_SEARCH_MISS_COUNT_EN
    check_eq("mrst_miss_count", lpm_miss_count, exp_miss);
`endif
    @(negedge AXI_ACLK);
    AXI_RESET = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge AXI_ACLK); #1;
      if (rsp_valid) seen++;
    end
    check_eq("mrst_no_rsp", seen, 32'd0);

    // Engine still works after the reset
    lookup(32'h0A020001, "postrst", 1'b1, 5'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
